// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISCVCPU performance monitor.
// No logic here; only the FSM encoding and the readout select map.
package riscv_pkg;

    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_RUN  = 2'd1,
        PM_DONE = 2'd2,
        PM_TMO  = 2'd3
    } pm_state_t;

    localparam int SEL_CYC   = 0;
    localparam int SEL_INSTR = 1;
    localparam int SEL_EVT0  = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Latency: q updates on the edge after inc; no backpressure (inc is a plain strobe).
// Holds at all-ones; ovf stays set until clr or reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         ovf
);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&q) begin
                ovf <= 1'b1;
            end else begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Run-controlled cycle/instruction/event counters with watchdog and readout mux.
// Latency: counters live, rd_data one cycle after rd_sel; no backpressure, strobes always accepted.
// clear overrides everything and returns the FSM to IDLE.
module perf_monitor
    import riscv_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 4,
    parameter int TIMEOUT = 2000,
    parameter int SEL_W   = $clog2(NUM_EVT + 2)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               done_in,
    input  logic               instr_retire,
    input  logic [NUM_EVT-1:0] evt,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   clock_count,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               busy,
    output logic               finished,
    output logic               timed_out,
    output logic [NUM_EVT+1:0] overflow
);

    localparam int NUM_CNT = NUM_EVT + 2;
    localparam int TMO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_M1);

    pm_state_t          state_q, state_d;
    logic               done_q;
    logic               done_rise;
    logic               tmo_hit;
    logic               run;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   cnt [NUM_CNT];

    assign run       = (state_q == PM_RUN);
    assign done_rise = done_in & ~done_q;
    assign tmo_hit   = (TIMEOUT != 0) && (clock_count == TMO_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= PM_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_in;
        end
    end

    // done_rise is checked before the watchdog so a simultaneous finish is not a timeout
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = PM_IDLE;
        end else begin
            case (state_q)
                PM_IDLE: if (start) state_d = PM_RUN;
                PM_RUN: begin
                    if (done_rise)    state_d = PM_DONE;
                    else if (tmo_hit) state_d = PM_TMO;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign inc[SEL_CYC]   = run;
    assign inc[SEL_INSTR] = run & instr_retire;

    genvar g;
    generate
        for (g = 0; g < NUM_EVT; g++) begin : g_evt_inc
            assign inc[SEL_EVT0+g] = run & evt[g];
        end
        for (g = 0; g < NUM_CNT; g++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .clr      (clear),
                .inc      (inc[g]),
                .q        (cnt[g]),
                .ovf      (overflow[g])
            );
        end
    endgenerate

    assign clock_count = cnt[SEL_CYC];
    assign instr_cnt   = cnt[SEL_INSTR];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (int'(rd_sel) < NUM_CNT) begin
            rd_data <= cnt[rd_sel];
        end else begin
            rd_data <= '0;
        end
    end

    assign busy      = (state_q == PM_RUN);
    assign finished  = (state_q == PM_DONE);
    assign timed_out = (state_q == PM_TMO);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: instance a (32-bit, 4 events, TIMEOUT=20)
// and instance b (8-bit, 2 events, watchdog off) for saturation.
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        reset;

    logic        start_a, clear_a, done_a, instr_a;
    logic [3:0]  evt_a;
    logic [2:0]  rd_sel_a;
    logic [31:0] rd_data_a, cc_a, ic_a;
    logic        busy_a, fin_a, tmo_a;
    logic [5:0]  ovf_a;

    logic        start_b, clear_b, done_b, instr_b;
    logic [1:0]  evt_b;
    logic [1:0]  rd_sel_b;
    logic [7:0]  rd_data_b, cc_b, ic_b;
    logic        busy_b, fin_b, tmo_b;
    logic [3:0]  ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    perf_monitor #(.CNT_W(32), .NUM_EVT(4), .TIMEOUT(20)) u_a (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start        (start_a),
        .clear        (clear_a),
        .done_in      (done_a),
        .instr_retire (instr_a),
        .evt          (evt_a),
        .rd_sel       (rd_sel_a),
        .rd_data      (rd_data_a),
        .clock_count  (cc_a),
        .instr_cnt    (ic_a),
        .busy         (busy_a),
        .finished     (fin_a),
        .timed_out    (tmo_a),
        .overflow     (ovf_a)
    );

    perf_monitor #(.CNT_W(8), .NUM_EVT(2), .TIMEOUT(0)) u_b (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start        (start_b),
        .clear        (clear_b),
        .done_in      (done_b),
        .instr_retire (instr_b),
        .evt          (evt_b),
        .rd_sel       (rd_sel_b),
        .rd_data      (rd_data_b),
        .clock_count  (cc_b),
        .instr_cnt    (ic_b),
        .busy         (busy_b),
        .finished     (fin_b),
        .timed_out    (tmo_b),
        .overflow     (ovf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {start_a, clear_a, done_a, instr_a} = '0;
        evt_a = '0; rd_sel_a = '0;
        {start_b, clear_b, done_b, instr_b} = '0;
        evt_b = '0; rd_sel_b = '0;
        step(); step();
        check("rst_cc", cc_a, 0);
        check("rst_flags", {29'd0, busy_a, fin_a, tmo_a}, 0);
        check("rst_ovf", {26'd0, ovf_a}, 0);
        check("rst_rd", rd_data_a, 0);
        reset = 1'b0;
        step();
        check("idle_busy", {31'd0, busy_a}, 0);

        // basic run: 10 RUN cycles, retire on odd cycles, evt[1] every cycle
        start_a = 1'b1; step(); start_a = 1'b0;
        check("run_busy", {31'd0, busy_a}, 1);
        for (int k = 1; k <= 10; k++) begin
            instr_a = (k % 2 == 1);
            evt_a   = 4'b0010;
            done_a  = (k == 10);
            step();
        end
        instr_a = 1'b0; evt_a = '0;
        check("basic_fin", {30'd0, fin_a, busy_a}, 2);
        check("basic_cc", cc_a, 10);
        check("basic_ic", ic_a, 5);
        check("basic_ovf", {26'd0, ovf_a}, 0);
        start_a = 1'b1; step(); start_a = 1'b0;
        check("done_ignores_start", {30'd0, fin_a, busy_a}, 2);
        rd_sel_a = 3'd3; step();
        check("rd_evt1", rd_data_a, 10);

        // clear returns to IDLE and zeroes counters
        clear_a = 1'b1; step(); clear_a = 1'b0;
        check("clr_state", {29'd0, busy_a, fin_a, tmo_a}, 0);
        check("clr_cc", cc_a, 0);

        // watchdog: done held low
        done_a = 1'b0;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int k = 1; k <= 19; k++) step();
        check("wd_pre_busy", {31'd0, busy_a}, 1);
        check("wd_pre_cc", cc_a, 19);
        step();
        check("wd_tmo", {29'd0, busy_a, fin_a, tmo_a}, 1);
        check("wd_cc", cc_a, 20);
        instr_a = 1'b1; evt_a = 4'hF; start_a = 1'b1;
        for (int k = 0; k < 50; k++) step();
        instr_a = 1'b0; evt_a = '0; start_a = 1'b0;
        check("wd_frozen_cc", cc_a, 20);
        check("wd_frozen_ic", ic_a, 0);
        check("wd_hold", {31'd0, tmo_a}, 1);
        clear_a = 1'b1; step(); clear_a = 1'b0;

        // tie-break: done rises in the cycle the watchdog would fire
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            done_a = (k == 20);
            step();
        end
        check("tie_state", {29'd0, busy_a, fin_a, tmo_a}, 2);
        check("tie_cc", cc_a, 20);
        clear_a = 1'b1; step(); clear_a = 1'b0;

        // done_in already high at start: no rise until it drops and returns
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step(); step();
        check("hi_done_busy", {31'd0, busy_a}, 1);
        done_a = 1'b0; step();
        done_a = 1'b1; step();
        check("hi_done_fin", {31'd0, fin_a}, 1);
        check("hi_done_cc", cc_a, 5);

        // readout after a 7-instruction run
        done_a = 1'b0;
        clear_a = 1'b1; step(); clear_a = 1'b0;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            instr_a = (k <= 7);
            done_a  = (k == 8);
            step();
        end
        instr_a = 1'b0;
        check("rd_run_ic", ic_a, 7);
        rd_sel_a = 3'd1; step();
        check("rd_instr", rd_data_a, 7);
        rd_sel_a = 3'd0; #2;
        check("rd_latency", rd_data_a, 7);
        step();
        check("rd_cyc", rd_data_a, 8);
        rd_sel_a = 3'd6; step();
        check("rd_oob", rd_data_a, 0);

        // clear beats start in the same IDLE cycle
        clear_a = 1'b1; step(); clear_a = 1'b0;
        clear_a = 1'b1; start_a = 1'b1; step();
        clear_a = 1'b0; start_a = 1'b0;
        check("clr_pri_busy", {31'd0, busy_a}, 0);
        step();
        check("clr_pri_idle", {31'd0, busy_a}, 0);

        // saturation on the 8-bit instance
        start_b = 1'b1; step(); start_b = 1'b0;
        evt_b = 2'b01;
        for (int k = 0; k < 300; k++) step();
        evt_b = '0;
        check("sat_cc", {24'd0, cc_b}, 255);
        check("sat_ovf", {28'd0, ovf_b}, 4'b0101);
        check("sat_busy", {31'd0, busy_b}, 1);
        rd_sel_b = 2'd2; step();
        check("sat_rd_evt0", {24'd0, rd_data_b}, 255);
        clear_b = 1'b1; step(); clear_b = 1'b0;
        check("sat_clr_cc", {24'd0, cc_b}, 0);
        check("sat_clr_ovf", {28'd0, ovf_b}, 0);
        check("sat_clr_busy", {31'd0, busy_b}, 0);

        // async reset mid-RUN
        done_a = 1'b0; rd_sel_a = 3'd0;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("ar_pre_cc", cc_a, 5);
        #2 reset = 1'b1;
        #1;
        check("ar_cc", cc_a, 0);
        check("ar_busy", {31'd0, busy_a}, 0);
        check("ar_rd", rd_data_a, 0);
        step();
        reset = 1'b0;
        step();
        check("ar_idle", {29'd0, busy_a, fin_a, tmo_a}, 0);
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step(); step();
        check("ar_fresh_cc", cc_a, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
